// File: rtl/multiplier.sv
// -----------------------------------------------------------------------------
// multiplier
//
// Iterative signed 33-bit multiply / divide unit.
//   - Multiply: 33 shift-add steps on operand magnitudes, then sign fix-up,
//     giving the exact 66-bit product {Aval, Bval}.
//   - Divide:   33 restoring shift-subtract steps on operand magnitudes, then
//     sign fix-up. Quotient truncates toward zero; the remainder takes the
//     sign of the dividend. Divide by zero gives quotient all-ones and
//     remainder = dividend.
//
// Start-to-result latency is 35 rising edges:
//   1 start edge (IDLE -> COMPUTE), 33 COMPUTE edges, 1 DONE edge.
//
// Handshake: ready is 1 only in IDLE. A start happens on any rising edge
// in IDLE with Run=1; opA, opB and div are sampled on that same edge and
// ignored at every other time. Results (Aval, Bval, X) are valid whenever
// ready is 1 and only ever change on the DONE edge or on Reset.
//
// Ports
//   Clk          in   clock, rising edge
//   Reset        in   asynchronous, active-high reset
//   Run          in   start request (level, sampled only in IDLE)
//   div          in   0 = multiply, 1 = divide
//   opA          in   33-bit signed multiplicand / dividend
//   opB          in   33-bit signed multiplier / divisor
//   Aval         out  multiply: product[65:33]; divide: remainder
//   Bval         out  multiply: product[32:0];  divide: quotient
//   X            out  sign-extension bit, equal to Aval[32]
//   ready        out  1 while IDLE (results valid, start accepted)
//   o_dbg_state  out  current FSM state (0 IDLE, 1 COMPUTE, 2 DONE)
// -----------------------------------------------------------------------------
module multiplier (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        div,
    input  logic [32:0] opA,
    input  logic [32:0] opB,
    output logic [32:0] Aval,
    output logic [32:0] Bval,
    output logic        X,
    output logic        ready,
    output logic [1:0]  o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t      r_state;
    logic [5:0]  r_cnt;
    logic        r_div;
    logic        r_neg_a;      // dividend sign, sets remainder sign
    logic        r_neg_res;    // product / quotient sign
    logic [32:0] r_op_a;       // raw dividend, returned as remainder on /0
    logic [32:0] r_mag_m;      // magnitude added (mul) or subtracted (div)
    logic [32:0] r_hi;         // mul: product high half; div: partial remainder
    logic [32:0] r_lo;         // mul: multiplier -> product low; div: dividend -> quotient
    logic [32:0] r_aval;
    logic [32:0] r_bval;
    logic        r_ready;

    // Magnitudes are 33-bit unsigned, so |-2^32| = 2^32 is exact.
    logic [32:0] w_mag_a;
    logic [32:0] w_mag_b;
    assign w_mag_a = opA[32] ? (~opA + 33'd1) : opA;
    assign w_mag_b = opB[32] ? (~opB + 33'd1) : opB;

    // Multiply step: conditionally add, then shift {sum, lo} right by one.
    // The high half stays below 2^33, so the 34-bit sum never overflows.
    logic [32:0] w_addend;
    logic [33:0] w_msum;
    assign w_addend = r_lo[0] ? r_mag_m : 33'd0;
    assign w_msum   = {1'b0, r_hi} + {1'b0, w_addend};

    // Divide step: shift next dividend bit into the partial remainder and
    // subtract the divisor if it fits. A successful difference is always
    // below the divisor magnitude, so 33 bits hold it.
    logic [33:0] w_dshift;
    logic        w_dge;
    logic [32:0] w_ddiff;
    assign w_dshift = {r_hi, r_lo[32]};
    assign w_dge    = (w_dshift >= {1'b0, r_mag_m});
    assign w_ddiff  = w_dshift[32:0] - r_mag_m;

    // Sign correction applied on the DONE edge.
    logic [65:0] w_prod;
    logic [65:0] w_prod_s;
    logic [32:0] w_quot_s;
    logic [32:0] w_rem_s;
    logic        w_div0;
    assign w_prod   = {r_hi, r_lo};
    assign w_prod_s = r_neg_res ? (~w_prod + 66'd1) : w_prod;
    assign w_quot_s = r_neg_res ? (~r_lo + 33'd1) : r_lo;
    assign w_rem_s  = r_neg_a ? (~r_hi + 33'd1) : r_hi;
    assign w_div0   = (r_mag_m == 33'd0);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= 6'd0;
            r_div     <= 1'b0;
            r_neg_a   <= 1'b0;
            r_neg_res <= 1'b0;
            r_op_a    <= 33'd0;
            r_mag_m   <= 33'd0;
            r_hi      <= 33'd0;
            r_lo      <= 33'd0;
            r_aval    <= 33'd0;
            r_bval    <= 33'd0;
            r_ready   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Run) begin
                        r_div     <= div;
                        r_neg_a   <= opA[32];
                        r_neg_res <= opA[32] ^ opB[32];
                        r_op_a    <= opA;
                        r_mag_m   <= div ? w_mag_b : w_mag_a;
                        r_lo      <= div ? w_mag_a : w_mag_b;
                        r_hi      <= 33'd0;
                        r_cnt     <= 6'd0;
                        r_ready   <= 1'b0;
                        r_state   <= S_COMPUTE;
                    end
                end

                S_COMPUTE: begin
                    if (r_div) begin
                        r_hi <= w_dge ? w_ddiff : w_dshift[32:0];
                        r_lo <= {r_lo[31:0], w_dge};
                    end else begin
                        r_hi <= w_msum[33:1];
                        r_lo <= {w_msum[0], r_lo[32:1]};
                    end
                    r_cnt <= r_cnt + 6'd1;
                    // Count 0..32 covers exactly 33 iterations.
                    if (r_cnt == 6'd32) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (!r_div) begin
                        r_aval <= w_prod_s[65:33];
                        r_bval <= w_prod_s[32:0];
                    end else if (w_div0) begin
                        r_aval <= r_op_a;
                        r_bval <= 33'h1_FFFF_FFFF;
                    end else begin
                        r_aval <= w_rem_s;
                        r_bval <= w_quot_s;
                    end
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign Aval        = r_aval;
    assign Bval        = r_bval;
    assign X           = r_aval[32];
    assign ready       = r_ready;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_multiplier.sv
// -----------------------------------------------------------------------------
// tb_multiplier
//
// Self-checking bench for the iterative multiply/divide unit: a table of
// directed vectors, hand-written handshake / back-to-back / mid-op reset
// sequences, and randomized operations checked against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_multiplier;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Reset;
    logic        Run;
    logic        div;
    logic [32:0] opA;
    logic [32:0] opB;
    logic [32:0] Aval;
    logic [32:0] Bval;
    logic        X;
    logic        ready;
    logic [1:0]  dbg_state;

    always #5 Clk = ~Clk;

    multiplier dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Run         (Run),
        .div         (div),
        .opA         (opA),
        .opB         (opB),
        .Aval        (Aval),
        .Bval        (Bval),
        .X           (X),
        .ready       (ready),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          errors = 0;
    logic [65:0] exp_q[$];

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: returns {Aval, Bval}.
    function automatic logic [65:0] model(input logic d, input logic [32:0] a, input logic [32:0] b);
        logic signed [65:0] pa, pb, p;
        logic signed [33:0] sa, sb, q, r;
        if (!d) begin
            pa = {{33{a[32]}}, a};
            pb = {{33{b[32]}}, b};
            p  = pa * pb;
            return p;
        end
        if (b == 33'd0) return {a, 33'h1_FFFF_FFFF};
        sa = {a[32], a};
        sb = {b[32], b};
        q  = sa / sb;
        r  = sa % sb;
        return {r[32:0], q[32:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic start_op(input logic d, input logic [32:0] a, input logic [32:0] b);
        @(negedge Clk);
        div = d; opA = a; opB = b; Run = 1'b1;
        @(posedge Clk);
        #1;
        Run = 1'b0;
    endtask

    // Counts rising edges until ready returns, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(posedge Clk);
            #1;
            n++;
        end
    endtask

    task automatic check_result(input string name, input logic [65:0] exp);
        check({name, " Aval"}, {33'd0, Aval}, {33'd0, exp[65:33]});
        check({name, " Bval"}, {33'd0, Bval}, {33'd0, exp[32:0]});
        check({name, " X"}, {65'd0, X}, {65'd0, exp[65]});
    endtask

    task automatic run_and_check(input string name, input logic d, input logic [32:0] a, input logic [32:0] b);
        int n;
        exp_q.push_back(model(d, a, b));
        start_op(d, a, b);
        wait_done(n);
        check({name, " latency"}, 66'(n), 66'd34);
        check_result(name, exp_q.pop_front());
    endtask

    function automatic logic [32:0] rand_op();
        logic [32:0] v;
        case ($urandom_range(0, 3))
            0: v = {1'($urandom_range(0, 1)), 32'($urandom)};
            1: v = 33'($signed(32'($urandom_range(0, 200)) - 32'd100));
            2: v = ($urandom_range(0, 1) != 0) ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
            default: v = 33'($urandom_range(0, 3));
        endcase
        return v;
    endfunction

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        d;
        logic [32:0] a;
        logic [32:0] b;
        logic [32:0] ea;
        logic [32:0] eb;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        logic [65:0] prev;
        logic [65:0] e1, e2;

        vecs[0]  = '{1'b0, 33'd0,          33'd500,        33'd0,          33'd0};
        vecs[1]  = '{1'b0, 33'd7,          33'h1_FFFF_FFFD, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFEB};
        vecs[2]  = '{1'b0, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_7FFF_FFFF, 33'd1};
        vecs[3]  = '{1'b0, 33'h1_0000_0000, 33'h1_0000_0000, 33'h0_8000_0000, 33'd0};
        vecs[4]  = '{1'b1, 33'd100,        33'd7,          33'd2,          33'd14};
        vecs[5]  = '{1'b1, 33'h1_FFFF_FFF9, 33'd2,          33'h1_FFFF_FFFF, 33'h1_FFFF_FFFD};
        vecs[6]  = '{1'b1, 33'd5,          33'd0,          33'd5,          33'h1_FFFF_FFFF};
        vecs[7]  = '{1'b1, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 33'd0,          33'h1_0000_0000};
        vecs[8]  = '{1'b1, 33'd7,          33'h1_FFFF_FFFE, 33'd1,          33'h1_FFFF_FFFD};
        vecs[9]  = '{1'b1, 33'h1_FFFF_FF9C, 33'd7,          33'h1_FFFF_FFFE, 33'h1_FFFF_FFF2};
        vecs[10] = '{1'b1, 33'h1_FFFF_FFFB, 33'd0,          33'h1_FFFF_FFFB, 33'h1_FFFF_FFFF};

        // Reset state
        Reset = 1'b1; Run = 1'b0; div = 1'b0; opA = '0; opB = '0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset Aval", {33'd0, Aval}, 66'd0);
        check("reset Bval", {33'd0, Bval}, 66'd0);
        check("reset X", {65'd0, X}, 66'd0);
        check("reset ready", {65'd0, ready}, 66'd1);
        @(negedge Clk);
        Reset = 1'b0;

        // Table-driven directed vectors
        for (int i = 0; i < 11; i++) begin
            start_op(vecs[i].d, vecs[i].a, vecs[i].b);
            check($sformatf("vec%0d ready low", i), {65'd0, ready}, 66'd0);
            wait_done(n);
            check($sformatf("vec%0d latency", i), 66'(n), 66'd34);
            check_result($sformatf("vec%0d", i), {vecs[i].ea, vecs[i].eb});
        end

        // Hold during COMPUTE; input toggling ignored
        run_and_check("pre-hold", 1'b0, 33'd7, 33'h1_FFFF_FFFD);
        prev = {Aval, Bval};
        start_op(1'b1, 33'd100, 33'd7);
        for (int i = 0; i < 15; i++) begin
            @(negedge Clk);
            opA = {1'($urandom_range(0, 1)), 32'($urandom)};
            opB = {1'($urandom_range(0, 1)), 32'($urandom)};
            div = 1'($urandom_range(0, 1));
        end
        check("hold ready", {65'd0, ready}, 66'd0);
        check("hold Aval", {33'd0, Aval}, {33'd0, prev[65:33]});
        check("hold Bval", {33'd0, Bval}, {33'd0, prev[32:0]});
        wait_done(n);
        check_result("hold result", {33'd2, 33'd14});

        // Back-to-back with Run held at 1; second operands set mid-op
        e1 = model(1'b0, 33'd1234, 33'h1_FFFF_FFF0);
        e2 = model(1'b0, 33'h1_FFFF_CFC7, 33'd678);
        @(negedge Clk);
        div = 1'b0; opA = 33'd1234; opB = 33'h1_FFFF_FFF0; Run = 1'b1;
        @(posedge Clk);
        #1;
        opA = 33'h1_FFFF_CFC7; opB = 33'd678;
        wait_done(n);
        check("b2b op1 latency", 66'(n), 66'd34);
        check_result("b2b op1", e1);
        @(posedge Clk);
        #1;
        check("b2b restart ready", {65'd0, ready}, 66'd0);
        check("b2b op1 held", {Aval, Bval}, e1);
        wait_done(n);
        Run = 1'b0;
        check("b2b op2 latency", 66'(n), 66'd34);
        check_result("b2b op2", e2);

        // Asynchronous reset at COMPUTE cycle 10
        start_op(1'b0, 33'd7, 33'd9);
        repeat (10) @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("midrst Aval", {33'd0, Aval}, 66'd0);
        check("midrst Bval", {33'd0, Bval}, 66'd0);
        check("midrst X", {65'd0, X}, 66'd0);
        check("midrst ready", {65'd0, ready}, 66'd1);
        check("midrst state", {64'd0, dbg_state}, 66'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (40) @(posedge Clk);
        #1;
        check("no stale result", {Aval, Bval}, 66'd0);
        check("no stale ready", {65'd0, ready}, 66'd1);
        run_and_check("post-reset start", 1'b1, 33'd100, 33'd7);

        // Randomized operations against the model
        for (int i = 0; i < 30; i++) begin
            run_and_check($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), rand_op(), rand_op());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
